msi_coherence_ctrl: RTL
=======================

// Module: msi_coherence_ctrl
// PURPOSE
//  Parametrised per-line snooping coherence controller for one private cache: 2**IDX_W line-state entries (MSI, optional MESI).
//  Accepts CPU read/write requests with an external tag-match flag, issues coherence messages on the shared bus through a
//  req/grant handshake, applies incoming snoops every cycle and pulses data write-back. Sits between the cache datapath and bus arbiter.
// PARAMETERS
//  IDX_W      3   line index width; NUM_LINES = 2**IDX_W state entries
// PORTS
//  clock        in   1      single clock, all state on posedge
//  reset        in   1      synchronous, active-high
//  cpu_valid    in   1      CPU request present; held until accepted
//  cpu_ready    out  1      comb: fsm==IDLE && !(snoop_valid && snoop_idx==cpu_idx); accept = cpu_valid&&cpu_ready
//  cpu_op       in   1      0 read, 1 write
//  cpu_idx      in   IDX_W  target line
//  cpu_tag_match in  1      external tag store hit for cpu_idx
//  snoop_valid  in   1      bus message from another cache this cycle
//  snoop_msg    in   3      000 read miss, 011 invalidate, 100 write miss, 101 fetch, 110 fetch invalidate
//  snoop_idx    in   IDX_W  snooped line
//  bus_req      out  1      registered; held until granted
//  bus_msg      out  3      registered; 000/011/100 while bus_req, else 111 (empty)
//  bus_idx      out  IDX_W  registered line of pending message
//  bus_grant    in   1      arbiter grant
//  bus_shared   in   1      other cache holds line (sampled at grant); used only with MESI_EXCLUSIVE_EN
//  wb           out  1      registered 1-cycle data write-back pulse
//  wb_idx       out  IDX_W  line written back
//  dbg_idx      in   IDX_W  debug read index;  dbg_state out 2: comb state of dbg_idx
// BEHAVIOUR
//  Line state: 00 I, 01 S, 10 M, 11 E (E only with macro). Reset: all lines I, fsm IDLE, bus_req 0, bus_msg 111,
//   bus_idx 0, wb 0, wb_idx 0. Reset during WAIT_GRANT drops the pending request.
//  FSM IDLE -> on accept: hit = cpu_tag_match && state!=I.
//   read hit: no message, state kept, stay IDLE (0-cycle).  write hit M: none. write hit E: silently -> M.
//   write hit S: bus_msg 011 -> WAIT_GRANT.  read miss: 000 -> WAIT_GRANT.  write miss: 100 -> WAIT_GRANT.
//   bus_req/bus_msg/bus_idx valid the cycle after accept, stable until grant.
//  WAIT_GRANT: grant honoured only when bus_grant && !snoop_valid; else request stays pending.
//   on honoured grant edge: 011 -> M; 100 -> M; 000 -> S. Miss on victim in M: wb=1, wb_idx=bus_idx next cycle.
//   fsm -> IDLE, bus_req 0, bus_msg 111 next cycle.
//  Snoop (any fsm state, every cycle; applied before CPU side):
//   I: ignored.  S: 011/100 -> I; 000/101 -> S.  M: 000/101 -> S+wb; 100/110 -> I+wb.  011 in M: ignored (illegal).
//   E: 000/101 -> S; 011/100/110 -> I; no wb.
//  Upgrade race: snoop 011/100 invalidating bus_idx while pending 011 -> pending converted to 100 (bus_msg updates next cycle).
//  Snoop wb and grant wb never coincide (grant blocked when snoop_valid).
// CONFIGURATION
//  MESI_EXCLUSIVE_EN defined: read miss with bus_shared=0 at grant -> E, else S; E transitions as above.
//  Undefined: state 11 never produced, bus_shared ignored, read miss always -> S.
// TESTING
//  reset; read idx2 match=0 -> bus_req=1, bus_msg=000, bus_idx=2; grant -> line2 S, bus_msg=111, wb=0.
//  line2 S, write match=1 -> bus_msg=011; grant -> line2 M; snoop 000 idx2 -> line2 S, wb=1, wb_idx=2.
//  line5 M, write idx5 match=0 -> bus_msg=100; grant -> wb=1, wb_idx=5, line5 M.
//  pending 011 idx3, snoop 100 idx3 with grant high -> grant ignored, line3 I, bus_msg=100; next grant -> line3 M.
//  cpu_valid idx1 with snoop_valid idx1 same cycle -> cpu_ready=0; snoop applied; accepted next cycle.
//  MESI_EXCLUSIVE_EN: read miss idx4, grant bus_shared=0 -> E; write hit -> M, no bus_req; without macro -> S.

Source files
------------

// File: rtl/msi_coherence_ctrl_if.sv
// rtl/msi_coherence_ctrl_if.sv - CPU, snoop, bus and debug signals of the MSI/MESI coherence controller
interface msi_coherence_ctrl_if #(
  parameter int IDX_W = 3
);

  // CPU request side
  logic             cpu_valid;
  logic             cpu_ready;
  logic             cpu_op;
  logic [IDX_W-1:0] cpu_idx;
  logic             cpu_tag_match;

  // Incoming snoops from other caches
  logic             snoop_valid;
  logic [2:0]       snoop_msg;
  logic [IDX_W-1:0] snoop_idx;

  // Outgoing coherence messages and arbiter handshake
  logic             bus_req;
  logic [2:0]       bus_msg;
  logic [IDX_W-1:0] bus_idx;
  logic             bus_grant;
  logic             bus_shared;

  // Data write-back pulse
  logic             wb;
  logic [IDX_W-1:0] wb_idx;

  // Debug state read
  logic [IDX_W-1:0] dbg_idx;
  logic [1:0]       dbg_state;

  // Environment view: CPU, snooping bus, arbiter and debug reader
  modport master (
    output cpu_valid, cpu_op, cpu_idx, cpu_tag_match,
    output snoop_valid, snoop_msg, snoop_idx,
    output bus_grant, bus_shared, dbg_idx,
    input  cpu_ready, bus_req, bus_msg, bus_idx, wb, wb_idx, dbg_state
  );

  // Controller view
  modport slave (
    input  cpu_valid, cpu_op, cpu_idx, cpu_tag_match,
    input  snoop_valid, snoop_msg, snoop_idx,
    input  bus_grant, bus_shared, dbg_idx,
    output cpu_ready, bus_req, bus_msg, bus_idx, wb, wb_idx, dbg_state
  );

endinterface

// File: rtl/msi_coherence_ctrl.sv
// rtl/msi_coherence_ctrl.sv - per-line snooping MSI controller, MESI E state when MESI_EXCLUSIVE_EN is defined
module msi_coherence_ctrl #(
  parameter int IDX_W = 3
) (
  input logic               clock,
  input logic               reset,
  msi_coherence_ctrl_if.slave ports
);

  localparam int NUM_LINES = 2 ** IDX_W;

  localparam logic [2:0] MSG_RD_MISS   = 3'b000;
  localparam logic [2:0] MSG_INV       = 3'b011;
  localparam logic [2:0] MSG_WR_MISS   = 3'b100;
  localparam logic [2:0] MSG_FETCH     = 3'b101;
  localparam logic [2:0] MSG_FETCH_INV = 3'b110;
  localparam logic [2:0] MSG_EMPTY     = 3'b111;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_M = 2'b10,
    ST_E = 2'b11
  } line_state_t;

  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_GRANT = 1'b1
  } fsm_t;

  line_state_t      lines [NUM_LINES];
  fsm_t             fsm;
  fsm_t             fsm_next;

  logic             bus_req_q;
  logic [2:0]       bus_msg_q;
  logic [IDX_W-1:0] bus_idx_q;
  logic             wb_q;
  logic [IDX_W-1:0] wb_idx_q;

  logic             cpu_ready;
  logic             accept;
  line_state_t      cpu_line;
  logic             cpu_hit;
  logic             need_msg;
  logic [2:0]       new_msg;
  logic             silent_upgrade;

  line_state_t      snoop_line;
  line_state_t      snoop_next;
  logic             snoop_wb;
  logic             race;

  logic             grant_ok;
  line_state_t      victim;
  line_state_t      grant_state;
  logic             grant_wb;

  // A snoop to the requested line must land first, so the CPU waits a cycle
  assign cpu_ready = (fsm == IDLE) && !(ports.snoop_valid && (ports.snoop_idx == ports.cpu_idx));
  assign accept    = ports.cpu_valid && cpu_ready;
  assign cpu_line  = lines[ports.cpu_idx];
  assign cpu_hit   = ports.cpu_tag_match && (cpu_line != ST_I);

  // Grant is refused in a snoop cycle so snoop and grant write-backs never collide
  assign grant_ok  = (fsm == WAIT_GRANT) && ports.bus_grant && !ports.snoop_valid;
  assign victim    = lines[bus_idx_q];
  assign grant_wb  = (bus_msg_q != MSG_INV) && (victim == ST_M);

  // A pending upgrade whose S copy is being invalidated must become a full write miss
  assign race = (fsm == WAIT_GRANT) && (bus_msg_q == MSG_INV) && ports.snoop_valid &&
                (ports.snoop_idx == bus_idx_q) &&
                ((ports.snoop_msg == MSG_INV) || (ports.snoop_msg == MSG_WR_MISS));

`ifdef MESI_EXCLUSIVE_EN
  // Read miss lands in E when no other cache reported a copy at grant
  always_comb begin
    grant_state = ST_M;
    if (bus_msg_q == MSG_RD_MISS) begin
      grant_state = ports.bus_shared ? ST_S : ST_E;
    end
  end
`else
  logic unused_bus_shared;
  assign unused_bus_shared = ports.bus_shared;

  // Read miss always lands in S; both write messages end in M
  always_comb begin
    grant_state = ST_M;
    if (bus_msg_q == MSG_RD_MISS) begin
      grant_state = ST_S;
    end
  end
`endif

  // Decode the CPU request into the bus message it needs, if any
  always_comb begin
    need_msg       = 1'b0;
    new_msg        = MSG_EMPTY;
    silent_upgrade = 1'b0;
    if (!ports.cpu_op) begin
      if (!cpu_hit) begin
        need_msg = 1'b1;
        new_msg  = MSG_RD_MISS;
      end
    end else if (!cpu_hit) begin
      need_msg = 1'b1;
      new_msg  = MSG_WR_MISS;
    end else if (cpu_line == ST_S) begin
      need_msg = 1'b1;
      new_msg  = MSG_INV;
    end else if (cpu_line == ST_E) begin
      silent_upgrade = 1'b1;
    end
  end

  // Next state of the snooped line and whether dirty data must be pushed out
  always_comb begin
    snoop_line = lines[ports.snoop_idx];
    snoop_next = snoop_line;
    snoop_wb   = 1'b0;
    if (ports.snoop_valid) begin
      case (snoop_line)
        ST_S: begin
          if ((ports.snoop_msg == MSG_INV) || (ports.snoop_msg == MSG_WR_MISS)) begin
            snoop_next = ST_I;
          end
        end
        ST_M: begin
          if ((ports.snoop_msg == MSG_RD_MISS) || (ports.snoop_msg == MSG_FETCH)) begin
            snoop_next = ST_S;
            snoop_wb   = 1'b1;
          end else if ((ports.snoop_msg == MSG_WR_MISS) || (ports.snoop_msg == MSG_FETCH_INV)) begin
            snoop_next = ST_I;
            snoop_wb   = 1'b1;
          end
        end
        ST_E: begin
          if ((ports.snoop_msg == MSG_RD_MISS) || (ports.snoop_msg == MSG_FETCH)) begin
            snoop_next = ST_S;
          end else if ((ports.snoop_msg == MSG_INV) || (ports.snoop_msg == MSG_WR_MISS) ||
                       (ports.snoop_msg == MSG_FETCH_INV)) begin
            snoop_next = ST_I;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Controller FSM next state: leave IDLE only when a message is needed
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:       if (accept && need_msg) fsm_next = WAIT_GRANT;
      WAIT_GRANT: if (grant_ok) fsm_next = IDLE;
      default:    fsm_next = IDLE;
    endcase
  end

  // Controller FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  // Bus request registers: load on accept, clear on grant, rewrite on upgrade race
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_req_q <= 1'b0;
      bus_msg_q <= MSG_EMPTY;
      bus_idx_q <= '0;
    end else if (fsm == IDLE && accept && need_msg) begin
      bus_req_q <= 1'b1;
      bus_msg_q <= new_msg;
      bus_idx_q <= ports.cpu_idx;
    end else if (grant_ok) begin
      bus_req_q <= 1'b0;
      bus_msg_q <= MSG_EMPTY;
    end else if (race) begin
      bus_msg_q <= MSG_WR_MISS;
    end
  end

  // One-cycle write-back pulse from either a snoop or an evicting grant
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q     <= 1'b0;
      wb_idx_q <= '0;
    end else begin
      wb_q <= snoop_wb || (grant_ok && grant_wb);
      if (snoop_wb) begin
        wb_idx_q <= ports.snoop_idx;
      end else if (grant_ok && grant_wb) begin
        wb_idx_q <= bus_idx_q;
      end
    end
  end

  // Line state array: snoop, grant and silent upgrade never target the same line in one cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        lines[i] <= ST_I;
      end
    end else begin
      if (ports.snoop_valid) begin
        lines[ports.snoop_idx] <= snoop_next;
      end
      if (grant_ok) begin
        lines[bus_idx_q] <= grant_state;
      end
      if (accept && silent_upgrade) begin
        lines[ports.cpu_idx] <= ST_M;
      end
    end
  end

  assign ports.cpu_ready = cpu_ready;
  assign ports.bus_req   = bus_req_q;
  assign ports.bus_msg   = bus_msg_q;
  assign ports.bus_idx   = bus_idx_q;
  assign ports.wb        = wb_q;
  assign ports.wb_idx    = wb_idx_q;
  assign ports.dbg_state = lines[ports.dbg_idx];

endmodule
